inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter PC_W, default 32, program-counter width.
REQ-002 Parameter ADDR_W, default 6, instruction-ROM word-address width.
REQ-003 Parameter DEPTH, default 4, prefetch-queue entries; legal values are powers of two, 2..16.
REQ-004 Port clk, in, 1, the single clock; all state updates on posedge clk.
REQ-005 Port Rst, in, 1, asynchronous active-high reset.
REQ-006 Port Write_PC, in, 1, fetch enable.
REQ-007 Port Branch, in, 1, redirect request.
REQ-008 Port Branch_target, in, PC_W, redirect address.
REQ-009 Port NZCV, in, 4, flags: [4]=N, [3]=Z, [2]=C, [1]=V.
REQ-010 Port rom_addr, out, ADDR_W, word address to a synchronous ROM.
REQ-011 Port rom_data, in, 32, ROM data, valid one cycle after rom_addr is presented.
REQ-012 Port ir_valid, out, 1, the head instruction passed its condition and is presented.
REQ-013 Port ir_ready, in, 1, consumer accepts IR.
REQ-014 Port IR, out, 28, head instruction bits [28:1].
REQ-015 Port IR_pc, out, PC_W, address of the head instruction.
REQ-016 Port condition_code, out, 4, head bits [32:29].
REQ-017 Port flag, out, 1, condition result for the head entry.

Function
REQ-018 rom_addr SHALL equal PC[ADDR_W+1:2].
REQ-019 A fetch SHALL issue when Write_PC=1, Branch=0, and (count + in-flight) < DEPTH.
- On issue, PC increments by 4 and an in-flight bit is set.
REQ-020 The in-flight word SHALL be pushed next cycle together with its PC.
REQ-021 flag SHALL decode the head condition_code combinationally from the current NZCV:
- 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V
- 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V
- 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0
REQ-022 With a non-empty queue:
- flag=1: ir_valid=1, and the head pops on ir_valid&ir_ready.
- flag=0: the head pops in that cycle with ir_valid=0 (squash).
REQ-023 With the queue empty, ir_valid SHALL be 0; IR and IR_pc hold their last value.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-025 Branch=1 SHALL take priority over pop, push and issue in the same cycle:
- count is cleared and the in-flight bit discarded, so rom_data is not pushed next cycle.
- PC is loaded with Branch_target.
- ir_valid is forced to 0 during the Branch cycle.
REQ-026 Fetching SHALL resume in the cycle after Branch.
- First valid IR is no earlier than 2 cycles after Branch.
REQ-027 Full-queue stall SHALL hold PC and rom_addr stable.

Reset
REQ-028 Rst SHALL asynchronously clear:
- PC to 0, count, pointers and in-flight to 0
- ir_valid to 0, IR to 0, IR_pc to 0
REQ-029 Rst asserted mid-fetch SHALL discard the outstanding ROM word.

Configuration
REQ-030 When INST_FETCH_SQUASH_CNT_EN is defined:
- A 16-bit output squash_cnt is added.
- squash_cnt increments on every REQ-022 squash and saturates at 16'hFFFF.
- Rst clears squash_cnt.
REQ-031 When INST_FETCH_SQUASH_CNT_EN is undefined, the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package inst_fetch_pkg SHALL hold:
- the 4-bit condition-code constants (EQ..NV)
- NZCV bit-index constants
- the queue-entry struct {pc, instr[32:1]}
REQ-033 Sub-module cond_eval (condition_code, NZCV -> flag) SHALL implement REQ-021 combinationally.

Verification
REQ-034 Reset, ROM[i]=32'hE000_0000|i, Write_PC=1, ir_ready=1:
- IR_pc sequence 0,4,8,... one per cycle after a 2-cycle fill.
REQ-035 ir_ready=0 for 10 cycles:
- Queue reaches DEPTH=4, PC stops at 16, no entry is lost on release.
REQ-036 Head condition 0000 with Z=0:
- The entry is squashed, ir_valid stays 0 that cycle, and the next entry is presented.
- With the macro defined, squash_cnt=1.
REQ-037 Branch=1 with target 0x40 while the queue is full and ir_ready=1:
- No pop occurs; the next valid IR_pc is 0x40.
- The in-flight word is never output.
REQ-038 Rst pulsed mid-stream:
- All outputs return to 0 immediately; fetch restarts from PC=0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// =============================================================================
// Module      : inst_fetch_pkg
// Description : Shared condition codes, flag indices and queue-entry type
//               for the instruction fetch queue.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package inst_fetch_pkg;

    localparam logic [3:0] c_EQ = 4'b0000;
    localparam logic [3:0] c_NE = 4'b0001;
    localparam logic [3:0] c_CS = 4'b0010;
    localparam logic [3:0] c_CC = 4'b0011;
    localparam logic [3:0] c_MI = 4'b0100;
    localparam logic [3:0] c_PL = 4'b0101;
    localparam logic [3:0] c_VS = 4'b0110;
    localparam logic [3:0] c_VC = 4'b0111;
    localparam logic [3:0] c_HI = 4'b1000;
    localparam logic [3:0] c_LS = 4'b1001;
    localparam logic [3:0] c_GE = 4'b1010;
    localparam logic [3:0] c_LT = 4'b1011;
    localparam logic [3:0] c_GT = 4'b1100;
    localparam logic [3:0] c_LE = 4'b1101;
    localparam logic [3:0] c_AL = 4'b1110;
    localparam logic [3:0] c_NV = 4'b1111;

    // NZCV is numbered 4 downto 1
    localparam int c_N_BIT = 4;
    localparam int c_Z_BIT = 3;
    localparam int c_C_BIT = 2;
    localparam int c_V_BIT = 1;

    // Widest supported PC; narrower PCs are zero-extended into an entry
    localparam int c_MAX_PC_W = 64;

    typedef struct packed {
        logic [c_MAX_PC_W-1:0] pc;
        logic [32:1]           instr;
    } queue_entry_t;

endpackage

`default_nettype wire

// File: rtl/cond_eval.sv
// =============================================================================
// Module      : cond_eval
// Description : Combinational decode of a 4-bit condition code against NZCV.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module cond_eval
    import inst_fetch_pkg::*;
(
    input  logic [3:0] condition_code,
    input  logic [4:1] NZCV,
    output logic       flag
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = NZCV[c_N_BIT];
    assign w_z = NZCV[c_Z_BIT];
    assign w_c = NZCV[c_C_BIT];
    assign w_v = NZCV[c_V_BIT];

    always_comb begin
        flag = 1'b0;
        case (condition_code)
            c_EQ:    flag = w_z;
            c_NE:    flag = !w_z;
            c_CS:    flag = w_c;
            c_CC:    flag = !w_c;
            c_MI:    flag = w_n;
            c_PL:    flag = !w_n;
            c_VS:    flag = w_v;
            c_VC:    flag = !w_v;
            c_HI:    flag = w_c && !w_z;
            c_LS:    flag = !w_c || w_z;
            c_GE:    flag = (w_n == w_v);
            c_LT:    flag = (w_n != w_v);
            c_GT:    flag = !w_z && (w_n == w_v);
            c_LE:    flag = w_z || (w_n != w_v);
            c_AL:    flag = 1'b1;
            c_NV:    flag = 1'b0;
            default: flag = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// =============================================================================
// Module      : inst_fetch_queue
// Description : Prefetching instruction queue in front of a synchronous ROM,
//               with conditional-execution squash and branch redirect.
//               Optional squash counter: define INST_FETCH_SQUASH_CNT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module inst_fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 4
)
(
    input  logic              clk,
    input  logic              Rst,
    input  logic              Write_PC,
    input  logic              Branch,
    input  logic [PC_W-1:0]   Branch_target,
    input  logic [4:1]        NZCV,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [27:0]       IR,
    output logic [PC_W-1:0]   IR_pc,
    output logic [3:0]        condition_code,
`ifdef INST_FETCH_SQUASH_CNT_EN
    output logic [15:0]       squash_cnt,
`endif
    output logic              flag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_inflight_pc;
    logic             r_inflight;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    queue_entry_t     r_mem [DEPTH];
    queue_entry_t     r_hold;

    logic             w_nonempty;
    logic [CNT_W:0]   w_occupancy;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_squash;
    logic             w_flag;
    queue_entry_t     w_head;
    queue_entry_t     w_push_entry;

    assign rom_addr    = r_pc[ADDR_W+1:2];
    assign w_nonempty  = (r_count != '0);
    assign w_occupancy = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
    assign w_issue     = Write_PC && !Branch && (w_occupancy < (CNT_W+1)'(DEPTH));
    assign w_push      = r_inflight && !Branch;

    // When empty, the outputs keep showing the last head that was presented
    assign w_head = w_nonempty ? r_mem[r_rd_ptr] : r_hold;

    assign IR             = w_head.instr[28:1];
    assign condition_code = w_head.instr[32:29];
    assign IR_pc          = PC_W'(w_head.pc);
    assign flag           = w_flag;

    cond_eval u_cond_eval (
        .condition_code (condition_code),
        .NZCV           (NZCV),
        .flag           (w_flag)
    );

    always_comb begin
        ir_valid = 1'b0;
        w_pop    = 1'b0;
        w_squash = 1'b0;
        if (w_nonempty && !Branch) begin
            ir_valid = w_flag;
            w_pop    = w_flag ? ir_ready : 1'b1;
            w_squash = !w_flag;
        end
    end

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.pc    = c_MAX_PC_W'(r_inflight_pc);
        w_push_entry.instr = rom_data;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_pc          <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_hold        <= '0;
        end else begin
            if (w_nonempty) begin
                r_hold <= r_mem[r_rd_ptr];
            end
            if (Branch) begin
                // Redirect wins: the outstanding ROM word is dropped
                r_pc       <= Branch_target;
                r_inflight <= 1'b0;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_pc          <= r_pc + PC_W'(4);
                    r_inflight_pc <= r_pc;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef INST_FETCH_SQUASH_CNT_EN
    logic [15:0] r_squash_cnt;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_squash_cnt <= '0;
        end else if (w_squash && (r_squash_cnt != 16'hFFFF)) begin
            r_squash_cnt <= r_squash_cnt + 16'd1;
        end
    end

    assign squash_cnt = r_squash_cnt;
`else
    logic w_squash_unused;
    assign w_squash_unused = w_squash;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// =============================================================================
// Module      : tb_inst_fetch_queue
// Description : Directed self-checking bench for inst_fetch_queue with a
//               behavioural synchronous ROM.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_inst_fetch_queue;

    logic        clk;
    logic        Rst;
    logic        Write_PC;
    logic        Branch;
    logic [31:0] Branch_target;
    logic [4:1]  NZCV;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [27:0] IR;
    logic [31:0] IR_pc;
    logic [3:0]  condition_code;
    logic        flag;
`ifdef INST_FETCH_SQUASH_CNT_EN
    logic [15:0] squash_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    inst_fetch_queue #(.PC_W(32), .ADDR_W(6), .DEPTH(4)) dut (
        .clk            (clk),
        .Rst            (Rst),
        .Write_PC       (Write_PC),
        .Branch         (Branch),
        .Branch_target  (Branch_target),
        .NZCV           (NZCV),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .IR             (IR),
        .IR_pc          (IR_pc),
        .condition_code (condition_code),
`ifdef INST_FETCH_SQUASH_CNT_EN
        .squash_cnt     (squash_cnt),
`endif
        .flag           (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word 10 is EQ (squashed with Z=0), word 13 is LT (squashed with N==V)
    function automatic logic [31:0] rom_word(input logic [5:0] a);
        if (a == 6'd10) return 32'h0000_000A;
        if (a == 6'd13) return 32'hB000_000D;
        return 32'hE000_0000 | {26'd0, a};
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst           = 1'b1;
        Write_PC      = 1'b1;
        Branch        = 1'b0;
        Branch_target = 32'h0;
        NZCV          = 4'b0000;
        ir_ready      = 1'b1;

        @(negedge clk);
        chk("rst_valid", 64'(ir_valid), 64'd0);
        chk("rst_ir", 64'(IR), 64'd0);
        chk("rst_irpc", 64'(IR_pc), 64'd0);
        chk("rst_romaddr", 64'(rom_addr), 64'd0);
        Rst = 1'b0;

        @(negedge clk);
        chk("fill_valid", 64'(ir_valid), 64'd0);
        chk("fill_romaddr", 64'(rom_addr), 64'd1);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            chk("stream_valid", 64'(ir_valid), 64'd1);
            chk("stream_irpc", 64'(IR_pc), 64'(4 * k));
            chk("stream_ir", 64'(IR), 64'(k));
            @(negedge clk);
        end

        // Asynchronous reset mid-stream
        Rst = 1'b1;
        #1;
        chk("arst_valid", 64'(ir_valid), 64'd0);
        chk("arst_ir", 64'(IR), 64'd0);
        chk("arst_irpc", 64'(IR_pc), 64'd0);
        chk("arst_romaddr", 64'(rom_addr), 64'd0);
        @(negedge clk);
        Rst      = 1'b0;
        ir_ready = 1'b0;

        repeat (10) @(negedge clk);
        chk("full_romaddr", 64'(rom_addr), 64'd4);
        chk("full_valid", 64'(ir_valid), 64'd1);
        chk("full_irpc", 64'(IR_pc), 64'd0);
        repeat (3) @(negedge clk);
        chk("full_romaddr_hold", 64'(rom_addr), 64'd4);

        ir_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("drain_valid", 64'(ir_valid), 64'd1);
            chk("drain_irpc", 64'(IR_pc), 64'(4 * k));
            @(negedge clk);
        end

        chk("sq_eq_cond", 64'(condition_code), 64'h0);
        chk("sq_eq_flag", 64'(flag), 64'd0);
        chk("sq_eq_valid", 64'(ir_valid), 64'd0);
        chk("sq_eq_irpc", 64'(IR_pc), 64'd40);
        @(negedge clk);
        chk("after_sq_valid", 64'(ir_valid), 64'd1);
        chk("after_sq_irpc", 64'(IR_pc), 64'd44);
`ifdef INST_FETCH_SQUASH_CNT_EN
        chk("squash_cnt_1", 64'(squash_cnt), 64'd1);
`endif
        @(negedge clk);
        chk("pc48_irpc", 64'(IR_pc), 64'd48);
        @(negedge clk);
        chk("sq_lt_cond", 64'(condition_code), 64'hB);
        chk("sq_lt_valid", 64'(ir_valid), 64'd0);
        chk("sq_lt_irpc", 64'(IR_pc), 64'd52);
        @(negedge clk);
        chk("after_lt_valid", 64'(ir_valid), 64'd1);
        chk("after_lt_irpc", 64'(IR_pc), 64'd56);
`ifdef INST_FETCH_SQUASH_CNT_EN
        chk("squash_cnt_2", 64'(squash_cnt), 64'd2);
`endif

        // Fill the queue behind head 56, then redirect while full
        ir_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("stall_irpc", 64'(IR_pc), 64'd56);
        chk("stall_romaddr", 64'(rom_addr), 64'd18);
        ir_ready      = 1'b1;
        Branch        = 1'b1;
        Branch_target = 32'h40;
        #1;
        chk("br_force_valid", 64'(ir_valid), 64'd0);
        @(negedge clk);
        Branch = 1'b0;
        chk("br_empty_valid", 64'(ir_valid), 64'd0);
        chk("br_romaddr", 64'(rom_addr), 64'd16);
        @(negedge clk);
        chk("br_fetch_valid", 64'(ir_valid), 64'd0);
        @(negedge clk);
        chk("br_first_valid", 64'(ir_valid), 64'd1);
        chk("br_first_irpc", 64'(IR_pc), 64'h40);
        chk("br_first_ir", 64'(IR), 64'd16);
        @(negedge clk);
        chk("br_next_irpc", 64'(IR_pc), 64'h44);

        // Redirect while a ROM word is outstanding; that word must never appear
        Branch        = 1'b1;
        Branch_target = 32'h80;
        @(negedge clk);
        Branch = 1'b0;
        chk("br2_empty_valid", 64'(ir_valid), 64'd0);
        @(negedge clk);
        chk("br2_inflight_valid", 64'(ir_valid), 64'd0);
        @(negedge clk);
        chk("br2_first_valid", 64'(ir_valid), 64'd1);
        chk("br2_first_irpc", 64'(IR_pc), 64'h80);
        chk("br2_first_ir", 64'(IR), 64'd32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
